// File: rtl/menu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : menu_pkg
// Purpose  : Shared types and constants for the title-menu controller:
//            menu state enum, RGB332 palette and active-low 7-segment codes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package menu_pkg;

   typedef enum logic [1:0] {
      BROWSE    = 2'd0,
      COUNTDOWN = 2'd1,
      LAUNCH    = 2'd2,
      PLAYING   = 2'd3
   } menu_state_t;

   // RGB332 palette
   localparam logic [7:0] c_rgb_black  = 8'h00;
   localparam logic [7:0] c_rgb_item   = 8'hFF;
   localparam logic [7:0] c_rgb_cursor = 8'hFC;
   localparam logic [7:0] c_rgb_bg     = 8'h25;

   // Active-low segments, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] c_seg_0   = 7'b1000000;
   localparam logic [6:0] c_seg_1   = 7'b1111001;
   localparam logic [6:0] c_seg_2   = 7'b0100100;
   localparam logic [6:0] c_seg_3   = 7'b0110000;
   localparam logic [6:0] c_seg_4   = 7'b0011001;
   localparam logic [6:0] c_seg_5   = 7'b0010010;
   localparam logic [6:0] c_seg_6   = 7'b0000010;
   localparam logic [6:0] c_seg_7   = 7'b1111000;
   localparam logic [6:0] c_seg_8   = 7'b0000000;
   localparam logic [6:0] c_seg_9   = 7'b0010000;
   localparam logic [6:0] c_seg_p   = 7'b0001100;
   localparam logic [6:0] c_seg_off = 7'b1111111;

   function automatic logic [6:0] seg_digit(input logic [3:0] d);
      case (d)
         4'd0:    return c_seg_0;
         4'd1:    return c_seg_1;
         4'd2:    return c_seg_2;
         4'd3:    return c_seg_3;
         4'd4:    return c_seg_4;
         4'd5:    return c_seg_5;
         4'd6:    return c_seg_6;
         4'd7:    return c_seg_7;
         4'd8:    return c_seg_8;
         4'd9:    return c_seg_9;
         default: return c_seg_off;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/menu_font_rom.sv
`default_nettype none
// ============================================================================
// Module   : menu_font_rom
// Purpose  : Combinational 5x7 font for digits 1-9. Bit 4 of the returned row
//            is the leftmost glyph column. Other digits/rows return blank.
// Ports    : digit [3:0] in  - digit to draw (1..9)
//            row   [2:0] in  - glyph row, 0 = top
//            bits  [4:0] out - lit columns of that row
// Revision : 1.0 - initial release
// ============================================================================
module menu_font_rom (
   input  logic [3:0] digit,
   input  logic [2:0] row,
   output logic [4:0] bits
);

   // Seven rows packed top-first: row 0 occupies [34:30]
   logic [34:0] w_glyph;

   always_comb begin
      case (digit)
         4'd1:    w_glyph = {5'b11100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b11111};
         4'd2:    w_glyph = {5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111};
         4'd3:    w_glyph = {5'b11110, 5'b00001, 5'b00001, 5'b01110, 5'b00001, 5'b00001, 5'b11110};
         4'd4:    w_glyph = {5'b00010, 5'b00110, 5'b01010, 5'b10010, 5'b11111, 5'b00010, 5'b00010};
         4'd5:    w_glyph = {5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b00001, 5'b10001, 5'b01110};
         4'd6:    w_glyph = {5'b00110, 5'b01000, 5'b10000, 5'b11110, 5'b10001, 5'b10001, 5'b01110};
         4'd7:    w_glyph = {5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000};
         4'd8:    w_glyph = {5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b10001, 5'b10001, 5'b01110};
         4'd9:    w_glyph = {5'b01110, 5'b10001, 5'b10001, 5'b01111, 5'b00001, 5'b00010, 5'b01100};
         default: w_glyph = '0;
      endcase

      case (row)
         3'd0:    bits = w_glyph[34:30];
         3'd1:    bits = w_glyph[29:25];
         3'd2:    bits = w_glyph[24:20];
         3'd3:    bits = w_glyph[19:15];
         3'd4:    bits = w_glyph[14:10];
         3'd5:    bits = w_glyph[9:5];
         3'd6:    bits = w_glyph[4:0];
         default: bits = 5'b00000;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/menu_controller.sv
`default_nettype none
// ============================================================================
// Module   : menu_controller
// Purpose  : Title menu. Player 1 browses N_ITEMS numbered items, confirms,
//            watches a cancellable frame-timed countdown, then the block
//            pulses start_game once. Renders the item row into the pixel
//            stream (1-cycle registered colour) and drives hex/LED status.
// Ports    : clk, rst                        - clock, sync active-high reset
//            frame_tick                      - 1-cycle pulse per frame
//            display_enable, pixel_x/pixel_y - VGA timing inputs
//            sw0_mode_select                 - 0 = 1 player, 1 = 2 players
//            p1_btn_left/right/confirm/back  - debounced button levels
//            game_over                       - 1-cycle pulse, back to menu
//            color_out_332                   - registered RGB332 pixel
//            hex0..hex3_out                  - active-low 7-segment digits
//            leds_out                        - one-hot cursor, [9]=menu_active
//            sel_index, num_players          - latched selection
//            start_game, menu_active         - game-state handshake
// Revision : 1.0 - initial release
// ============================================================================
module menu_controller #(
   parameter int N_ITEMS        = 4,
   parameter int SCALE          = 8,
   parameter int MENU_LEFT      = 160,
   parameter int MENU_TOP       = 200,
   parameter int CHAR_SP        = 16,
   parameter int FRAMES_PER_SEC = 60,
   parameter int COUNT_SECS     = 3,
   parameter int BLINK_FRAMES   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       display_enable,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   input  logic       sw0_mode_select,
   input  logic       p1_btn_left,
   input  logic       p1_btn_right,
   input  logic       p1_btn_confirm,
   input  logic       p1_btn_back,
   input  logic       game_over,
   output logic [7:0] color_out_332,
   output logic [6:0] hex0_out,
   output logic [6:0] hex1_out,
   output logic [6:0] hex2_out,
   output logic [6:0] hex3_out,
   output logic [9:0] leds_out,
   output logic [3:0] sel_index,
   output logic [1:0] num_players,
   output logic       start_game,
   output logic       menu_active
);

   import menu_pkg::*;

   localparam int c_fc_w    = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
   localparam int c_bc_w    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int c_glyph_w = 5 * SCALE;
   localparam int c_glyph_h = 7 * SCALE;
   localparam int c_pitch   = 5 * SCALE + CHAR_SP;

   localparam logic [c_fc_w-1:0] c_frame_last = c_fc_w'(FRAMES_PER_SEC - 1);
   localparam logic [c_bc_w-1:0] c_blink_last = c_bc_w'(BLINK_FRAMES - 1);
   localparam logic [3:0]        c_item_last  = 4'(N_ITEMS - 1);

   menu_state_t         r_state,   w_state_n;
   logic [3:0]          r_cursor,  w_cursor_n;
   logic [3:0]          r_sel,     w_sel_n;
   logic [1:0]          r_players, w_players_n;
   logic [3:0]          r_sec,     w_sec_n;
   logic [c_fc_w-1:0]   r_frame,   w_frame_n;
   logic [c_bc_w-1:0]   r_bcnt,    w_bcnt_n;
   logic                r_blink,   w_blink_n;
   logic [3:0]          r_btn_q;
   logic [3:0]          w_btn, w_ev;
   logic [7:0]          r_color,   w_color;

   // {left, right, confirm, back}; r_btn_q resets high so a held button
   // produces no event on reset release.
   assign w_btn = {p1_btn_left, p1_btn_right, p1_btn_confirm, p1_btn_back};
   assign w_ev  = w_btn & ~r_btn_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= BROWSE;
         r_cursor  <= '0;
         r_sel     <= '0;
         r_players <= 2'd1;
         r_sec     <= '0;
         r_frame   <= '0;
         r_bcnt    <= '0;
         r_blink   <= 1'b1;
         r_btn_q   <= '1;
      end else begin
         r_state   <= w_state_n;
         r_cursor  <= w_cursor_n;
         r_sel     <= w_sel_n;
         r_players <= w_players_n;
         r_sec     <= w_sec_n;
         r_frame   <= w_frame_n;
         r_bcnt    <= w_bcnt_n;
         r_blink   <= w_blink_n;
         r_btn_q   <= w_btn;
      end
   end

   always_comb begin
      w_state_n   = r_state;
      w_cursor_n  = r_cursor;
      w_sel_n     = r_sel;
      w_players_n = r_players;
      w_sec_n     = r_sec;
      w_frame_n   = r_frame;
      w_bcnt_n    = r_bcnt;
      w_blink_n   = r_blink;
      case (r_state)
         BROWSE: begin
            if (w_ev[1]) begin
               w_sel_n     = r_cursor;
               w_players_n = sw0_mode_select ? 2'd2 : 2'd1;
               w_sec_n     = 4'(COUNT_SECS);
               w_frame_n   = '0;
               w_bcnt_n    = '0;
               w_blink_n   = 1'b1;
               w_state_n   = COUNTDOWN;
            end else if (w_ev[3] && !w_ev[2]) begin
               w_cursor_n = (r_cursor == 4'd0) ? c_item_last : r_cursor - 4'd1;
            end else if (w_ev[2] && !w_ev[3]) begin
               w_cursor_n = (r_cursor == c_item_last) ? 4'd0 : r_cursor + 4'd1;
            end
         end
         COUNTDOWN: begin
            if (w_ev[0]) begin
               w_state_n = BROWSE;
            end else if (frame_tick) begin
               if (r_bcnt == c_blink_last) begin
                  w_bcnt_n  = '0;
                  w_blink_n = ~r_blink;
               end else begin
                  w_bcnt_n = r_bcnt + 1'b1;
               end
               if (r_frame == c_frame_last) begin
                  w_frame_n = '0;
                  // Last second expiring launches instead of showing 0
                  if (r_sec == 4'd1) w_state_n = LAUNCH;
                  else               w_sec_n   = r_sec - 4'd1;
               end else begin
                  w_frame_n = r_frame + 1'b1;
               end
            end
         end
         LAUNCH: begin
            w_state_n = PLAYING;
         end
         PLAYING: begin
            if (game_over) begin
               w_state_n  = BROWSE;
               w_cursor_n = r_sel;
            end
         end
         default: w_state_n = BROWSE;
      endcase
   end

   // ---------------------------------------------------------------- render
   int         w_px, w_py, w_col, w_row;
   logic       w_hit, w_lit, w_is_cur;
   logic [3:0] w_item, w_digit;
   logic [2:0] w_font_row;
   logic [4:0] w_bits;

   always_comb begin
      w_px   = int'(pixel_x);
      w_py   = int'(pixel_y);
      w_hit  = 1'b0;
      w_item = '0;
      w_col  = 0;
      w_row  = (w_py - MENU_TOP) / SCALE;
      for (int i = 0; i < N_ITEMS; i++) begin
         if (w_px >= MENU_LEFT + i * c_pitch &&
             w_px <  MENU_LEFT + i * c_pitch + c_glyph_w &&
             w_py >= MENU_TOP && w_py < MENU_TOP + c_glyph_h) begin
            w_hit  = 1'b1;
            w_item = 4'(i);
            w_col  = (w_px - MENU_LEFT - i * c_pitch) / SCALE;
         end
      end
      w_font_row = 3'(w_row);
      w_digit    = w_item + 4'd1;
   end

   menu_font_rom u_font (
      .digit (w_digit),
      .row   (w_font_row),
      .bits  (w_bits)
   );

   always_comb begin
      w_is_cur = (w_item == r_cursor);
      w_lit    = w_hit && ((w_bits & (5'b10000 >> w_col)) != 5'b00000);
      // Cursor glyph blanks during the off half of the countdown blink
      if (w_is_cur && r_state == COUNTDOWN && !r_blink) w_lit = 1'b0;
      if (!display_enable || r_state == PLAYING) w_color = c_rgb_black;
      else if (w_lit)                            w_color = w_is_cur ? c_rgb_cursor : c_rgb_item;
      else                                       w_color = c_rgb_bg;
   end

   always_ff @(posedge clk) begin
      if (rst) r_color <= c_rgb_black;
      else     r_color <= w_color;
   end

   // ---------------------------------------------------------------- status
   assign color_out_332 = r_color;
   assign sel_index     = r_sel;
   assign num_players   = r_players;
   assign start_game    = (r_state == LAUNCH);
   assign menu_active   = (r_state == BROWSE) || (r_state == COUNTDOWN);
   assign hex0_out      = seg_digit((r_state == BROWSE) ? (sw0_mode_select ? 4'd2 : 4'd1)
                                                        : {2'b00, r_players});
   assign hex1_out      = c_seg_p;
   assign hex2_out      = seg_digit(r_cursor + 4'd1);
   assign hex3_out      = (r_state == COUNTDOWN) ? seg_digit(r_sec) : c_seg_off;

   always_comb begin
      leds_out = '0;
      for (int i = 0; i < N_ITEMS; i++) leds_out[i] = (r_cursor == 4'(i));
      leds_out[9] = menu_active;
   end

endmodule
`default_nettype wire

// File: tb/tb_menu_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_menu_controller
// Purpose  : Self-checking bench for menu_controller with a behavioural
//            model (tick counts since confirm, modular cursor arithmetic)
//            compared every cycle, plus hand-computed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_menu_controller;

   localparam int N_ITEMS = 4, SCALE = 8, MENU_LEFT = 160, MENU_TOP = 200;
   localparam int CHAR_SP = 16, FPS = 60, COUNT_SECS = 3, BLINK = 8;
   localparam int S_BROWSE = 0, S_COUNTDOWN = 1, S_LAUNCH = 2, S_PLAYING = 3;

   logic       clk = 1'b0;
   logic       rst, frame_tick, display_enable, sw0, bl, br, bc, bb, game_over;
   logic [9:0] pixel_x, pixel_y;
   logic [7:0] color_out_332;
   logic [6:0] hex0_out, hex1_out, hex2_out, hex3_out;
   logic [9:0] leds_out;
   logic [3:0] sel_index;
   logic [1:0] num_players;
   logic       start_game, menu_active;

   menu_controller #(
      .N_ITEMS(N_ITEMS), .SCALE(SCALE), .MENU_LEFT(MENU_LEFT), .MENU_TOP(MENU_TOP),
      .CHAR_SP(CHAR_SP), .FRAMES_PER_SEC(FPS), .COUNT_SECS(COUNT_SECS), .BLINK_FRAMES(BLINK)
   ) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .display_enable(display_enable),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .sw0_mode_select(sw0),
      .p1_btn_left(bl), .p1_btn_right(br), .p1_btn_confirm(bc), .p1_btn_back(bb),
      .game_over(game_over), .color_out_332(color_out_332),
      .hex0_out(hex0_out), .hex1_out(hex1_out), .hex2_out(hex2_out), .hex3_out(hex3_out),
      .leds_out(leds_out), .sel_index(sel_index), .num_players(num_players),
      .start_game(start_game), .menu_active(menu_active)
   );

   always #5 clk = ~clk;

   // Font bitmaps for digits 1..9 (index 0 = digit 1), leftmost column = bit 4
   logic [4:0] font [9][7] = '{
      '{5'b11100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b11111},
      '{5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111},
      '{5'b11110, 5'b00001, 5'b00001, 5'b01110, 5'b00001, 5'b00001, 5'b11110},
      '{5'b00010, 5'b00110, 5'b01010, 5'b10010, 5'b11111, 5'b00010, 5'b00010},
      '{5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b00001, 5'b10001, 5'b01110},
      '{5'b00110, 5'b01000, 5'b10000, 5'b11110, 5'b10001, 5'b10001, 5'b01110},
      '{5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000},
      '{5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b10001, 5'b10001, 5'b01110},
      '{5'b01110, 5'b10001, 5'b10001, 5'b01111, 5'b00001, 5'b00010, 5'b01100}};
   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   int vectors = 0, miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------ model
   int         m_st, m_cursor, m_sel, m_players, m_t;
   bit         m_valid = 1'b0;
   logic [7:0] m_color;
   logic [3:0] m_prev;

   function automatic logic [7:0] model_color();
      int px, py, x0, col, row;
      logic [4:0] f;
      logic lit;
      if (!display_enable || m_st == S_PLAYING) return 8'h00;
      px = int'(pixel_x);
      py = int'(pixel_y);
      for (int i = 0; i < N_ITEMS; i++) begin
         x0 = MENU_LEFT + i * (5 * SCALE + CHAR_SP);
         if (px >= x0 && px < x0 + 5 * SCALE && py >= MENU_TOP && py < MENU_TOP + 7 * SCALE) begin
            col = (px - x0) / SCALE;
            row = (py - MENU_TOP) / SCALE;
            f   = font[i][row];
            lit = f[4 - col];
            if (i == m_cursor && m_st == S_COUNTDOWN && ((m_t / BLINK) % 2) == 1) lit = 1'b0;
            if (lit) return (i == m_cursor) ? 8'hFC : 8'hFF;
         end
      end
      return 8'h25;
   endfunction

   always @(posedge clk) begin
      logic [3:0] btns, ev;
      btns = {bl, br, bc, bb};
      if (rst) begin
         m_st = S_BROWSE; m_cursor = 0; m_sel = 0; m_players = 1; m_t = 0;
         m_color = 8'h00; m_prev = 4'hF; m_valid = 1'b1;
      end else begin
         m_color = model_color();
         ev      = btns & ~m_prev;
         m_prev  = btns;
         case (m_st)
            S_BROWSE:
               if (ev[1]) begin
                  m_sel = m_cursor; m_players = sw0 ? 2 : 1; m_t = 0; m_st = S_COUNTDOWN;
               end else if (ev[3] && !ev[2]) m_cursor = (m_cursor + N_ITEMS - 1) % N_ITEMS;
               else if (ev[2] && !ev[3])     m_cursor = (m_cursor + 1) % N_ITEMS;
            S_COUNTDOWN:
               if (ev[0]) m_st = S_BROWSE;
               else if (frame_tick) begin
                  m_t++;
                  if (m_t == COUNT_SECS * FPS) m_st = S_LAUNCH;
               end
            S_LAUNCH:  m_st = S_PLAYING;
            default:
               if (game_over) begin m_st = S_BROWSE; m_cursor = m_sel; end
         endcase
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("color", color_out_332, m_color);
         check("hex0", hex0_out, seg_tab[(m_st == S_BROWSE) ? (sw0 ? 2 : 1) : m_players]);
         check("hex1", hex1_out, 7'b0001100);
         check("hex2", hex2_out, seg_tab[m_cursor + 1]);
         check("hex3", hex3_out, (m_st == S_COUNTDOWN) ? seg_tab[COUNT_SECS - m_t / FPS] : 7'h7F);
         check("leds", leds_out, (10'd1 << m_cursor) |
               ((m_st == S_BROWSE || m_st == S_COUNTDOWN) ? 10'h200 : 10'h000));
         check("sel_index", sel_index, m_sel);
         check("num_players", num_players, m_players);
         check("start_game", start_game, m_st == S_LAUNCH);
         check("menu_active", menu_active, m_st == S_BROWSE || m_st == S_COUNTDOWN);
      end
   end

   // ------------------------------------------------------------ stimulus
   bit sweep = 1'b0;

   task automatic step();
      @(posedge clk);
      #1;
      if (sweep) begin
         if (pixel_x >= 10'd420) begin
            pixel_x = 10'd150;
            pixel_y = (pixel_y >= 10'd260) ? 10'd190 : pixel_y + 10'd3;
         end else begin
            pixel_x = pixel_x + 10'd7;
         end
         display_enable = (pixel_x < 10'd400);
      end
   endtask

   task automatic set_btn(input int which, input logic v);
      case (which)
         0:       bl = v;
         1:       br = v;
         2:       bc = v;
         default: bb = v;
      endcase
   endtask

   task automatic press(input int which);
      set_btn(which, 1'b1); step();
      set_btn(which, 1'b0); step();
   endtask

   task automatic ftick(input int n);
      repeat (n) begin
         frame_tick = 1'b1; step();
         frame_tick = 1'b0; step();
      end
   endtask

   task automatic at_pixel(input int x, input int y, input logic de);
      pixel_x = 10'(x); pixel_y = 10'(y); display_enable = de; step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; frame_tick = 0; display_enable = 0; pixel_x = 0; pixel_y = 0;
      sw0 = 0; bl = 0; br = 0; bc = 0; bb = 0; game_over = 0;
      repeat (3) step();
      rst = 1'b0; step();
      check("rst_leds", leds_out, 10'b1000000001);
      check("rst_sel", sel_index, 0);
      check("rst_players", num_players, 1);
      check("rst_active", menu_active, 1);
      check("rst_start", start_game, 0);
      check("rst_hex3", hex3_out, 7'b1111111);
      check("rst_color", color_out_332, 8'h00);

      sweep = 1'b1;
      repeat (5) press(1);
      check("right5_leds", leds_out, 10'b1000000010);
      check("right5_hex2", hex2_out, 7'b0100100);
      press(0); press(0);
      check("left_wrap_leds", leds_out, 10'b1000001000);
      bl = 1; br = 1; step(); bl = 0; br = 0; step();
      check("lr_same_leds", leds_out, 10'b1000001000);
      press(1);
      check("wrap_to0_hex2", hex2_out, 7'b1111001);

      sweep = 1'b0;
      at_pixel(164, 200, 1'b1);  check("pix_cursor", color_out_332, 8'hFC);
      at_pixel(164, 200, 1'b0);  check("pix_blank", color_out_332, 8'h00);
      at_pixel(226, 200, 1'b1);  check("pix_item", color_out_332, 8'hFF);
      at_pixel(100, 100, 1'b1);  check("pix_bg", color_out_332, 8'h25);
      at_pixel(164, 200, 1'b1);

      press(2);
      check("cd_hex3", hex3_out, 7'b0110000);
      check("cd_hex0", hex0_out, 7'b1111001);
      ftick(8);  check("blink_off", color_out_332, 8'h25);
      ftick(8);  check("blink_on", color_out_332, 8'hFC);
      ftick(54); check("t70_hex3", hex3_out, 7'b0100100);
      bb = 1; frame_tick = 1; step(); bb = 0; frame_tick = 0; step();
      check("back_hex3", hex3_out, 7'b1111111);
      check("back_cursor", hex2_out, 7'b1111001);
      check("back_active", menu_active, 1);

      sweep = 1'b1;
      press(1); press(1); sw0 = 1'b1;
      press(2);
      check("cd2_hex0", hex0_out, 7'b0100100);
      ftick(59); check("t59_hex3", hex3_out, 7'b0110000);
      ftick(1);  check("t60_hex3", hex3_out, 7'b0100100);
      ftick(60); check("t120_hex3", hex3_out, 7'b1111001);
      ftick(59); check("t179_start", start_game, 0);
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      check("launch_start", start_game, 1);
      check("launch_active", menu_active, 0);
      step();
      check("play_start", start_game, 0);
      check("play_active", menu_active, 0);
      check("play_players", num_players, 2);
      check("play_sel", sel_index, 2);

      press(1);
      check("play_ignore", hex2_out, 7'b0110000);
      check("play_color", color_out_332, 8'h00);
      game_over = 1'b1; step(); game_over = 1'b0; step();
      check("go_active", menu_active, 1);
      check("go_leds", leds_out, 10'b1000000100);

      press(2); ftick(30);
      rst = 1'b1; step(); step(); rst = 1'b0; step();
      check("abort_leds", leds_out, 10'b1000000001);
      check("abort_start", start_game, 0);
      check("abort_players", num_players, 1);

      br = 1'b1; rst = 1'b1; step(); step(); rst = 1'b0;
      repeat (3) step();
      check("held_leds", leds_out, 10'b1000000001);
      br = 1'b0; step();
      press(1);
      check("after_held_leds", leds_out, 10'b1000000010);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
